// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg
//   Shared constants for the boot loader: default bus widths, the default
//   number of words copied at boot, and the FSM state encodings.
package boot_loader_pkg;

    localparam int ADDR_SIZE          = 16;
    localparam int WORD_SIZE          = 16;
    localparam int BOOT_WORDS_DEFAULT = 3;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if
//   Bundles the ROM read side and RAM write side of the boot path.
//   master : the loader (drives addresses, write request/data, status)
//   slave  : the memory side (drives ROM data and RAM acknowledge)
//   rom_addr/rom_data : ROM address out, shared ROM data bus in
//   ram_we/ram_addr/ram_wdata/ram_ack : RAM write request and acknowledge
//   boot_done/word_cnt : copy status
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE,
    parameter int DATA_W = WORD_SIZE
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic              boot_done;
    logic [ADDR_W-1:0] word_cnt;

    modport master (
        output rom_addr, ram_we, ram_addr, ram_wdata, boot_done, word_cnt,
        input  rom_data, ram_ack
    );

    modport slave (
        input  rom_addr, ram_we, ram_addr, ram_wdata, boot_done, word_cnt,
        output rom_data, ram_ack
    );
endinterface

// File: rtl/boot_settle_cnt.sv
// boot_settle_cnt
//   Down-counter that times how long the ROM address is held before the
//   data bus is sampled. While load is high it sits at SETTLE-1; while load
//   is low it counts down to zero and stays there.
//   clk  : clock
//   rst  : synchronous active-high reset
//   load : reload request (high whenever the loader is not fetching)
//   zero : count has reached zero, data may be captured after this cycle
module boot_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);
    // Holds SETTLE-1, so SETTLE=1 needs a single bit.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/boot_loader.sv
// boot_loader
//   Copies BOOT_WORDS words from the program ROM into RAM after reset, then
//   raises a sticky boot_done so the CPU can take over the shared bus.
//   Each word: hold rom_addr for SETTLE cycles (FETCH), latch rom_data and
//   present the RAM write (CAPTURE), hold the write until ram_ack (WRITE).
//   clk : clock, rst : synchronous active-high reset
//   bus : boot_loader_if master modport (ROM address/data, RAM write
//         handshake, boot_done, word_cnt); all outputs are registered.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_SIZE,
    parameter int DATA_W     = WORD_SIZE,
    parameter int BOOT_WORDS = BOOT_WORDS_DEFAULT,
    parameter int ADDR_STEP  = 2,
    parameter int RAM_BASE   = 0,
    parameter int SETTLE     = 1
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus
);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(RAM_BASE);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BOOT_WORDS);

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              boot_done_q, boot_done_d;
    logic [ADDR_W-1:0] word_cnt_q,  word_cnt_d;

    logic              settle_zero;
    logic [ADDR_W-1:0] word_cnt_inc;

    // The counter reloads in every state except FETCH, so it is already
    // primed with SETTLE-1 on the first FETCH cycle.
    boot_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (state_q != FETCH),
        .zero (settle_zero)
    );

    assign word_cnt_inc = word_cnt_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        boot_done_d = boot_done_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            IDLE: begin
                if (BOOT_WORDS == 0) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (settle_zero) begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // rom_data is copied unchecked; address wraps modulo 2**ADDR_W.
                ram_wdata_d = bus.rom_data;
                ram_addr_d  = BASE_A + word_cnt_q * STEP_A;
                ram_we_d    = 1'b1;
                state_d     = WRITE;
            end

            WRITE: begin
                if (bus.ram_ack) begin
                    ram_we_d   = 1'b0;
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == LAST_A) begin
                        // Raise boot_done on the committing edge itself.
                        state_d     = DONE;
                        boot_done_d = 1'b1;
                    end else begin
                        rom_addr_d = rom_addr_q + STEP_A;
                        state_d    = FETCH;
                    end
                end
            end

            DONE: begin
                // Also covers the empty-copy path, which enters DONE
                // straight from IDLE without a committing write.
                boot_done_d = 1'b1;
                ram_we_d    = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                ram_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            boot_done_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            boot_done_q <= boot_done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.boot_done = boot_done_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Bus master on the program-ROM side of the boot path.
- After reset it walks ROM word addresses, samples the shared ROM data bus while the ROM still drives it, and writes each word into RAM through a write/acknowledge handshake.
- When the last word is committed it raises boot_done. The ROM then tri-states the shared bus and the CPU takes ownership.

Parameters:
- ADDR_W, `ADDR_SIZE, address width of the ROM and RAM address buses.
- DATA_W, `WORD_SIZE, width of the ROM data bus and RAM write data.
- BOOT_WORDS, 3, number of 16-bit words copied. Constraint: 2*BOOT_WORDS <= 2**ADDR_W.
- ADDR_STEP, 2, ROM/RAM address increment per word (byte addressing, 2-byte words).
- RAM_BASE, 0, RAM destination address of the first word.
- SETTLE, 1, cycles the address is held before data is sampled (ROM is combinational; minimum 1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- rom_addr, output, ADDR_W, ROM address, registered.
- rom_data, input, DATA_W, shared ROM data bus, sampled only while boot_done=0.
- ram_we, output, 1, RAM write request, registered.
- ram_addr, output, ADDR_W, RAM write address, registered.
- ram_wdata, output, DATA_W, RAM write data, registered.
- ram_ack, input, 1, RAM accepted the write this cycle.
- boot_done, output, 1, boot copy complete; sticky until rst.
- word_cnt, output, ADDR_W, words committed so far.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: rom_addr, ram_we, ram_addr, ram_wdata, boot_done, word_cnt.
  - Reset mid-copy aborts the copy, drops ram_we the next edge, and the copy restarts from ROM address 0.
- FSM states: IDLE, FETCH, CAPTURE, WRITE, DONE.
- IDLE:
  - If BOOT_WORDS=0, go to DONE.
  - Otherwise go to FETCH the first cycle after rst deasserts.
- FETCH:
  - rom_addr is stable.
  - The settle counter counts SETTLE cycles, then the FSM goes to CAPTURE.
- CAPTURE (one cycle):
  - ram_wdata <= rom_data.
  - ram_addr <= RAM_BASE + word_cnt*ADDR_STEP, truncated to ADDR_W.
  - ram_we <= 1.
  - Go to WRITE.
- WRITE:
  - ram_we holds at 1, and ram_addr and ram_wdata hold stable, until ram_ack=1 is sampled.
  - On ack:
    - ram_we <= 0.
    - word_cnt <= word_cnt+1.
    - If word_cnt+1 == BOOT_WORDS, go to DONE.
    - Otherwise rom_addr <= rom_addr+ADDR_STEP and go to FETCH.
  - There is no timeout. The FSM stalls indefinitely without ack.
- DONE:
  - boot_done=1 and ram_we=0.
  - rom_addr and ram_addr hold their last values.
  - rom_data is ignored (it is Z once the ROM releases the bus).
- Per-word latency is SETTLE + 1 + ack wait cycles, minimum SETTLE+2. With SETTLE=1 and ack in the first WRITE cycle, one word takes 3 cycles.
- Address arithmetic wraps modulo 2**ADDR_W. ram_addr wrap is legal; the parameter constraint prevents rom_addr overlap.
- rom_data = X/Z at the CAPTURE edge is copied as-is. The loader does no checking.
- ram_ack while ram_we=0 is ignored.

Decomposition:
- Shared package/header (the top macro file):
  - ADDR_SIZE and WORD_SIZE.
  - FSM state encodings as localparams IDLE=0, FETCH=1, CAPTURE=2, WRITE=3, DONE=4.
  - BOOT_WORDS default.
- Natural sub-module: boot_settle_cnt, a small down-counter that loads SETTLE and flags zero. Inlining is acceptable.

Test Plan:
- Default parameters; ROM model 0x0000@0, 0x0005@2, 0xFFFD@4; RAM acks same cycle -> RAM writes (0,0x0000), (2,0x0005), (4,0xFFFD); boot_done rises on cycle 10 after rst release; word_cnt=3.
- RAM ack delayed 4 cycles on word 1 -> ram_we, ram_addr=2 and ram_wdata=0x0005 held stable through the stall; no duplicate write; boot_done 4 cycles later.
- rst asserted while in WRITE of word 2 -> next edge ram_we=0 and all outputs 0; copy restarts and rewrites address 0 first.
- BOOT_WORDS=0 -> boot_done=1 two cycles after rst release; ram_we never asserted.
- RAM_BASE=0x10, SETTLE=3 -> writes land at 0x10/0x12/0x14; each word spends 3 FETCH cycles.
- After boot_done, drive rom_data to Z and toggle ram_ack -> no state change; boot_done stays 1.
